// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave terminating one burst at a time onto a single-port synchronous SRAM
module axi_sram_slave #(
  parameter int ADDR_BITS = 20,
  parameter int ID_W      = 4
) (
  input  logic                 aclk_i,
  input  logic                 aresetn_i,
  input  logic [ID_W-1:0]      arid_i,
  input  logic [31:0]          araddr_i,
  input  logic [7:0]           arlen_i,
  input  logic [2:0]           arsize_i,
  input  logic [1:0]           arburst_i,
  input  logic                 arvalid_i,
  output logic                 arready_o,
  output logic [ID_W-1:0]      rid_o,
  output logic [31:0]          rdata_o,
  output logic [1:0]           rresp_o,
  output logic                 rlast_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  input  logic [ID_W-1:0]      awid_i,
  input  logic [31:0]          awaddr_i,
  input  logic [7:0]           awlen_i,
  input  logic [2:0]           awsize_i,
  input  logic [1:0]           awburst_i,
  input  logic                 awvalid_i,
  output logic                 awready_o,
  input  logic [ID_W-1:0]      wid_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           wstrb_i,
  input  logic                 wlast_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [ID_W-1:0]      bid_o,
  output logic [1:0]           bresp_o,
  output logic                 bvalid_o,
  input  logic                 bready_i,
  output logic                 mem_en_o,
  output logic [3:0]           mem_we_o,
  output logic [ADDR_BITS-3:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic        size_err, wrap_err, slv_err, dec_err, last_beat, mem_ok;
  logic        none_valid, ar_sel, aw_sel;
  logic [31:0] step, wrap_mask, next_addr;
  logic        unused_ok;

  assign unused_ok = ^wid_i;

  assign size_err  = size_q > 3'd2;
  assign wrap_err  = (burst_q == 2'b10) &&
                     !(len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
  assign slv_err   = size_err | wrap_err;
  assign dec_err   = (addr_q >> ADDR_BITS) != 32'd0;
  assign mem_ok    = !dec_err && !slv_err;
  assign last_beat = beat_q == len_q;
  assign step      = 32'd1 << size_q;
  assign wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;

  always_comb begin
    next_addr = addr_q + step;
    if (burst_q == 2'b00) begin
      next_addr = addr_q;
    end else if (burst_q == 2'b10) begin
      next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
    end
  end

  // Pointer picks the winner on a tie and also which ready is shown while both valids are low.
  assign none_valid = !arvalid_i && !awvalid_i;
  assign ar_sel = (arvalid_i && (!awvalid_i || !rr_q)) || (none_valid && !rr_q);
  assign aw_sel = (awvalid_i && (!arvalid_i || rr_q))  || (none_valid && rr_q);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_o = 1'b0;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    mem_en_o  = 1'b0;
    mem_we_o  = 4'd0;
    case (state_q)
      IDLE: begin
        arready_o = ar_sel && aresetn_i;
        awready_o = aw_sel && aresetn_i;
        if (arready_o && arvalid_i) begin
          id_d = arid_i; addr_d = araddr_i; len_d = arlen_i;
          size_d = arsize_i; burst_d = arburst_i;
          beat_d = 8'd0; rr_d = !rr_q; state_d = RD_REQ;
        end else if (awready_o && awvalid_i) begin
          id_d = awid_i; addr_d = awaddr_i; len_d = awlen_i;
          size_d = awsize_i; burst_d = awburst_i;
          beat_d = 8'd0; err_d = 2'b00; rr_d = !rr_q; state_d = WR_DATA;
        end
      end
      RD_REQ: begin
        mem_en_o = mem_ok;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = mem_ok ? mem_rdata_i : 32'd0;
        rresp_d = dec_err ? 2'b11 : (slv_err ? 2'b10 : 2'b00);
        state_d = RD_RESP;
      end
      RD_RESP: begin
        if (rready_i) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_en_o = mem_ok;
          mem_we_o = mem_ok ? wstrb_i : 4'd0;
          // DECERR is sticky over SLVERR once any beat falls outside the SRAM.
          if (dec_err) begin
            err_d = 2'b11;
          end else if (err_q != 2'b11 && (slv_err || (wlast_i != last_beat))) begin
            err_d = 2'b10;
          end
          addr_d = next_addr;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready_i) begin
          err_d   = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= '0;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      beat_q  <= 8'd0;
      err_q   <= 2'd0;
      rdata_q <= 32'd0;
      rresp_q <= 2'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign rvalid_o    = state_q == RD_RESP;
  assign rlast_o     = rvalid_o && last_beat;
  assign rid_o       = id_q;
  assign rdata_o     = rdata_q;
  assign rresp_o     = rresp_q;
  assign bvalid_o    = state_q == WR_RESP;
  assign bid_o       = id_q;
  assign bresp_o     = err_q;
  assign mem_addr_o  = addr_q[ADDR_BITS-1:2];
  assign mem_wdata_o = wdata_i;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed table-driven bench for axi_sram_slave with a behavioural SRAM
module tb_axi_sram_slave;

  logic        aclk, aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata, mem_wdata, mem_rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready, mem_en;
  logic [3:0]  wstrb, mem_we;
  logic [17:0] mem_addr;

  axi_sram_slave #(.ADDR_BITS(20), .ID_W(4)) dut (
    .aclk_i(aclk), .aresetn_i(aresetn),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Behavioural SRAM: contents reload while reset is low.
  logic [31:0] mem [0:1023];
  always @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[10'h040] <= 32'h11111111;
      mem[10'h041] <= 32'h22222222;
      mem[10'h042] <= 32'h33333333;
      mem[10'h043] <= 32'h44444444;
      mem[10'h100] <= 32'hDEADBEEF;
      for (int i = 0; i < 8; i++) mem[10'h080 + i] <= 32'h80000000 + i;
    end else if (mem_en) begin
      if (mem_we == 4'd0) mem_rdata <= mem[mem_addr[9:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int en_cnt = 0;
  int overlap = 0;
  always @(posedge aclk) if (mem_en) en_cnt++;
  always @(negedge aclk) if (arready && awready) overlap++;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  // Waits for the selected ready, checks the other is low, handshakes and drops valid.
  task automatic hold_until(input bit is_aw, input string nm);
    int n = 0;
    #1;
    while (!(is_aw ? awready : arready) && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    chk({nm, "_ready"}, is_aw ? awready : arready, 1);
    chk({nm, "_excl"}, is_aw ? arready : awready, 0);
    @(posedge aclk); #1;
    if (is_aw) awvalid = 1'b0; else arvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    @(negedge aclk);
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    hold_until(1'b0, "ar");
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    @(negedge aclk);
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    hold_until(1'b1, "aw");
  endtask

  task automatic get_r(input int stall, output logic [31:0] d, output logic [1:0] rs,
                       output logic l, output logic [3:0] id, output int lat);
    lat = 0;
    do begin @(negedge aclk); lat++; end while (!rvalid && lat < 100);
    chk("r_valid", rvalid, 1);
    d = rdata; rs = rresp; l = rlast; id = rid;
    for (int s = 0; s < stall; s++) begin
      @(negedge aclk);
      chk("r_hold_valid", rvalid, 1);
      chk("r_hold_data", rdata, d);
      chk("r_hold_last", rlast, l);
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic l,
                        input logic exp_en, input logic [17:0] exp_addr);
    int n = 0;
    @(negedge aclk);
    wdata = d; wstrb = st; wlast = l; wvalid = 1'b1;
    #1;
    while (!wready && n < 50) begin @(negedge aclk); #1; n++; end
    chk("w_ready", wready, 1);
    chk("w_mem_en", mem_en, exp_en);
    if (exp_en) begin
      chk("w_mem_we", mem_we, st);
      chk("w_mem_addr", mem_addr, exp_addr);
      chk("w_mem_wdata", mem_wdata, d);
    end
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] exp_resp, input logic [3:0] exp_id);
    int n = 0;
    @(negedge aclk);
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    chk("b_valid", bvalid, 1);
    chk("b_resp", bresp, exp_resp);
    chk("b_id", bid, exp_id);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_en;
  } rvec_t;

  rvec_t vec [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    logic        l;
    logic [3:0]  id;
    int          lat, e0, n;
    logic [31:0] wrap_exp [4];

    vec[0] = '{4'd3, 32'h0000_0400, 3'd2, 2'b01, 32'hDEADBEEF, 2'b00, 1};
    vec[1] = '{4'd1, 32'h0000_0104, 3'd2, 2'b00, 32'h22222222, 2'b00, 1};
    vec[2] = '{4'd2, 32'h0010_0000, 3'd2, 2'b01, 32'h00000000, 2'b11, 0};
    vec[3] = '{4'd5, 32'h0000_010C, 3'd3, 2'b01, 32'h00000000, 2'b10, 0};
    vec[4] = '{4'd6, 32'h0000_010E, 3'd1, 2'b01, 32'h44444444, 2'b00, 1};
    vec[5] = '{4'd7, 32'hFFFF_FFFC, 3'd2, 2'b01, 32'h00000000, 2'b11, 0};
    vec[6] = '{4'd8, 32'h0000_0200, 3'd0, 2'b11, 32'h80000000, 2'b00, 1};
    wrap_exp[0] = 32'h33333333; wrap_exp[1] = 32'h44444444;
    wrap_exp[2] = 32'h11111111; wrap_exp[3] = 32'h22222222;

    aresetn = 1'b0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    repeat (3) @(negedge aclk);
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    aresetn = 1'b1;

    // Round-robin: simultaneous requests go read, write, read.
    @(negedge aclk);
    arid = 4'd1; araddr = 32'h400; arlen = 0; arsize = 2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd2; awaddr = 32'h40; awlen = 0; awsize = 2; awburst = 2'b01; awvalid = 1'b1;
    hold_until(1'b0, "arb0");
    arid = 4'd4; araddr = 32'h104; arvalid = 1'b1;
    get_r(0, d, rs, l, id, lat);
    chk("arb0_data", d, 32'hDEADBEEF);
    chk("arb0_id", id, 4'd1);
    hold_until(1'b1, "arb1");
    send_w(32'h0BADF00D, 4'hF, 1'b1, 1'b1, 18'h10);
    get_b(2'b00, 4'd2);
    awid = 4'd5; awaddr = 32'h44; awvalid = 1'b1;
    hold_until(1'b0, "arb2");
    get_r(0, d, rs, l, id, lat);
    chk("arb2_data", d, 32'h22222222);
    chk("arb2_id", id, 4'd4);
    hold_until(1'b1, "arb3");
    send_w(32'h01020304, 4'hF, 1'b1, 1'b1, 18'h11);
    get_b(2'b00, 4'd5);

    for (int i = 0; i < 7; i++) begin
      e0 = en_cnt;
      send_ar(vec[i].id, vec[i].addr, 8'd0, vec[i].size, vec[i].burst);
      get_r(0, d, rs, l, id, lat);
      chk($sformatf("v%0d_data", i), d, vec[i].exp_data);
      chk($sformatf("v%0d_resp", i), rs, vec[i].exp_resp);
      chk($sformatf("v%0d_id", i), id, vec[i].id);
      chk($sformatf("v%0d_last", i), l, 1);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_en", i), en_cnt - e0, vec[i].exp_en);
    end

    // WRAP burst with a 5-cycle rready stall on beat 1.
    send_ar(4'hA, 32'h108, 8'd3, 3'd2, 2'b10);
    for (int k = 0; k < 4; k++) begin
      get_r((k == 1) ? 5 : 0, d, rs, l, id, lat);
      chk($sformatf("wrap%0d_data", k), d, wrap_exp[k]);
      chk($sformatf("wrap%0d_last", k), l, (k == 3) ? 1 : 0);
      chk($sformatf("wrap%0d_resp", k), rs, 0);
      chk($sformatf("wrap%0d_lat", k), lat, 3);
    end

    send_ar(4'hB, 32'h100, 8'd2, 3'd2, 2'b10);
    for (int k = 0; k < 3; k++) begin
      get_r(0, d, rs, l, id, lat);
      chk($sformatf("badwrap%0d_resp", k), rs, 2'b10);
    end

    send_aw(4'hC, 32'h20, 8'd1, 3'd2, 2'b01);
    send_w(32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 18'h8);
    send_w(32'h12345678, 4'h3, 1'b1, 1'b1, 18'h9);
    get_b(2'b00, 4'hC);
    send_ar(4'h1, 32'h20, 8'd1, 3'd2, 2'b01);
    get_r(0, d, rs, l, id, lat);
    chk("rb0_data", d, 32'hCAFEF00D);
    chk("rb0_last", l, 0);
    get_r(0, d, rs, l, id, lat);
    chk("rb1_data", d, 32'h00005678);
    chk("rb1_last", l, 1);

    send_aw(4'hD, 32'h30, 8'd1, 3'd2, 2'b01);
    send_w(32'h1, 4'hF, 1'b1, 1'b1, 18'hC);
    send_w(32'h2, 4'hF, 1'b1, 1'b1, 18'hD);
    get_b(2'b10, 4'hD);

    send_aw(4'hE, 32'h0010_0000, 8'd0, 3'd2, 2'b01);
    send_w(32'h3, 4'hF, 1'b1, 1'b0, 18'h0);
    get_b(2'b11, 4'hE);

    send_aw(4'hF, 32'h40, 8'd0, 3'd3, 2'b01);
    send_w(32'h4, 4'hF, 1'b1, 1'b0, 18'h0);
    get_b(2'b10, 4'hF);

    // Reset asserted while beat 2 of an 8-beat read is waiting.
    send_ar(4'h9, 32'h200, 8'd7, 3'd2, 2'b01);
    get_r(0, d, rs, l, id, lat);
    chk("rst_b0_data", d, 32'h80000000);
    get_r(0, d, rs, l, id, lat);
    chk("rst_b1_data", d, 32'h80000001);
    n = 0;
    do begin @(negedge aclk); n++; end while (!rvalid && n < 20);
    chk("rst_b2_valid", rvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("rst_async_rvalid", rvalid, 0);
    chk("rst_async_arready", arready, 0);
    chk("rst_async_mem_en", mem_en, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rst_rel_arready", arready, 1);
    chk("rst_rel_rvalid", rvalid, 0);
    send_ar(4'h6, 32'h400, 8'd0, 3'd2, 2'b01);
    get_r(0, d, rs, l, id, lat);
    chk("fresh_data", d, 32'hDEADBEEF);
    chk("fresh_id", id, 4'h6);
    chk("fresh_lat", lat, 3);

    chk("ready_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
